branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, predictor table depth; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port if_pc  input  XLEN  fetch-stage PC for lookup.
REQ-006 SHALL have port pred_taken  output  1  predicted taken for if_pc.
REQ-007 SHALL have port pred_target  output  XLEN  predicted target for if_pc.
REQ-008 SHALL have port ex_valid  input  1  EX stage holds a valid instruction.
REQ-009 SHALL have port ex_branch  input  1  EX instruction is a conditional branch.
REQ-010 SHALL have port ex_op  input  3  condition select.
REQ-011 SHALL have ports ex_a, ex_b  input  XLEN  compare operands.
REQ-012 SHALL have ports ex_pc, ex_target  input  XLEN  branch PC, computed target.
REQ-013 SHALL have ports ex_pred_taken (1), ex_pred_target (XLEN)  input  prediction carried down the pipe.
REQ-014 SHALL have ports flush  output  1, redirect_pc  output  XLEN  registered mispredict recovery.
REQ-015 SHALL have ports stat_branches, stat_mispredicts  output  32  event counters.

Function
REQ-016 SHALL decode ex_op: 000 a==b; 001 a<0; 010 a!=b; 011 a<=0; 100 a>0; 101 a>=0; 110 signed a<b; 111 unsigned a<b; sign tests on bit XLEN-1.
REQ-017 SHALL define resolve = ex_valid & ex_branch, and taken = resolve & condition.
REQ-018 SHALL index the table with PC[IDX+1:2], IDX=log2(ENTRIES); tag = PC[XLEN-1:IDX+2].
REQ-019 SHALL store per entry: valid bit, tag, target (XLEN), 2-bit saturating counter.
REQ-020 SHALL compute lookup combinationally: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = hit ? entry target : if_pc+4.
REQ-021 SHALL on resolve with hit: increment counter if taken, decrement if not, saturating at 11/00; overwrite target when taken.
REQ-022 SHALL on resolve with miss and taken: allocate entry, valid=1, tag, target=ex_target, ctr=10.
REQ-023 SHALL on resolve with miss and not taken: leave table unchanged.
REQ-024 SHALL define mispredict = resolve & ((taken != ex_pred_taken) | (taken & ex_pred_target != ex_target)).
REQ-025 SHALL register flush <= mispredict one cycle after resolve; flush high exactly one cycle per mispredict.
REQ-026 SHALL register redirect_pc <= taken ? ex_target : ex_pc+4 when mispredict, else hold.
REQ-027 SHALL give lookup old table contents when lookup and update hit the same index in one cycle; no bypass.
REQ-028 SHALL increment stat_branches on every resolve and stat_mispredicts on every mispredict, wrapping modulo 2^32.
REQ-029 SHALL ignore ex_op, operands and prediction inputs when resolve is low; no state change.
REQ-030 SHALL compute PC+4 modulo 2^XLEN.

Reset
REQ-031 SHALL, with rst_n low at a rising edge, clear all valid bits, set all counters to 01, clear flush, redirect_pc, both stat counters.
REQ-032 SHALL let reset win over a simultaneous resolve; no update or flush from that cycle.
REQ-033 SHALL drive pred_taken=0, pred_target=if_pc+4 in the cycle after reset.

Structure
REQ-034 SHALL place ex_op encodings, counter constants (SNT=00, WNT=01, WT=10, ST=11) in shared package branch_pkg.
REQ-035 SHALL isolate condition evaluation in combinational sub-module branch_cond (XLEN-parameterised).
REQ-036 SHALL keep the table as a register array; no vendor RAM.

Verification
REQ-037 SHALL cover: reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-038 SHALL cover: resolve BEQ at pc=0x100, a=b=5, target=0x200, pred_taken=0 -> next cycle flush=1, redirect_pc=0x200; then if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-039 SHALL cover: same branch resolved not-taken twice -> counter 10->01->00, pred_taken=0; second resolve flush=0 (pred 0).
REQ-040 SHALL cover: op 110 a=0xFFFFFFFF b=1 -> taken; op 111 same operands -> not taken.
REQ-041 SHALL cover: aliasing pcs 0x100 and 0x140 (ENTRIES=16) -> tag mismatch, no hit; allocation of 0x140 evicts 0x100.
REQ-042 SHALL cover: rst_n low in the cycle a mispredict resolves -> flush stays 0, stat counters 0, table empty.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: condition selects and
// 2-bit saturating counter states with their step helpers.
package branch_pkg;

   // ex_op condition selects
   localparam logic [2:0] OP_EQ   = 3'b000;  // a == b
   localparam logic [2:0] OP_LTZ  = 3'b001;  // a <  0
   localparam logic [2:0] OP_NE   = 3'b010;  // a != b
   localparam logic [2:0] OP_LEZ  = 3'b011;  // a <= 0
   localparam logic [2:0] OP_GTZ  = 3'b100;  // a >  0
   localparam logic [2:0] OP_GEZ  = 3'b101;  // a >= 0
   localparam logic [2:0] OP_LT   = 3'b110;  // signed a < b
   localparam logic [2:0] OP_LTU  = 3'b111;  // unsigned a < b

   // 2-bit saturating counter; MSB is the taken prediction
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   function automatic ctr_t ctr_inc(input ctr_t c);
      ctr_t r;
      if (c == CTR_ST) r = CTR_ST;
      else             r = ctr_t'(c + 2'b01);
      return r;
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      ctr_t r;
      if (c == CTR_SNT) r = CTR_SNT;
      else              r = ctr_t'(c - 2'b01);
      return r;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator; sign tests use the operand MSB.
module branch_cond
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            cond
);

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic                   a_neg;
   logic                   a_zero;

   assign a_s    = a;
   assign b_s    = b;
   assign a_neg  = a[XLEN-1];
   assign a_zero = (a == '0);

   // Select the comparison named by op
   always_comb begin
      cond = 1'b0;
      unique case (op)
         OP_EQ:   cond = (a == b);
         OP_LTZ:  cond = a_neg;
         OP_NE:   cond = (a != b);
         OP_LEZ:  cond = a_neg | a_zero;
         OP_GTZ:  cond = ~a_neg & ~a_zero;
         OP_GEZ:  cond = ~a_neg;
         OP_LT:   cond = (a_s < b_s);
         OP_LTU:  cond = (a < b);
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, resolved in EX.
// Lookup is combinational from the table; updates land at the clock edge,
// so a same-cycle lookup of the updated index sees the old entry.
module branch_predictor
   import branch_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [2:0]      ex_op,
   input  logic [XLEN-1:0] ex_a,
   input  logic [XLEN-1:0] ex_b,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // Table storage: control bits are reset, tag/target are data only
   logic             valid_q [ENTRIES];
   ctr_t             ctr_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [XLEN-1:0]  tgt_q   [ENTRIES];

   logic [IDX-1:0]   if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   logic [IDX-1:0]   ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;

   logic             cond;
   logic             resolve;
   logic             taken;
   logic             mispredict;

   branch_cond #(.XLEN(XLEN)) u_cond (
      .op   (ex_op),
      .a    (ex_a),
      .b    (ex_b),
      .cond (cond)
   );

   assign if_idx = if_pc[IDX+1:2];
   assign if_tag = if_pc[XLEN-1:IDX+2];
   assign ex_idx = ex_pc[IDX+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX+2];

   assign resolve    = ex_valid & ex_branch;
   assign taken      = resolve & cond;
   assign mispredict = resolve & ((taken != ex_pred_taken) |
                                  (taken & (ex_pred_target != ex_target)));

   // Fetch-side lookup against the current table contents
   always_comb begin
      if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken  = 1'b0;
      pred_target = if_pc + PC_STEP;
      if (if_hit) begin
         pred_taken  = ctr_q[if_idx][1];
         pred_target = tgt_q[if_idx];
      end
   end

   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // Valid bits and counters: train on hit, allocate on taken miss
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WNT;
         end
      end else if (resolve) begin
         if (ex_hit) begin
            ctr_q[ex_idx] <= taken ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
         end else if (taken) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= CTR_WT;
         end
      end
   end

   // Tag and target payload, written whenever a taken branch resolves
   always_ff @(posedge clk) begin
      if (rst_n && taken) begin
         tag_q[ex_idx] <= ex_tag;
         tgt_q[ex_idx] <= ex_target;
      end
   end

   // Mispredict recovery: one-cycle flush pulse and held redirect address
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict) begin
            redirect_pc <= taken ? ex_target : ex_pc + PC_STEP;
         end
      end
   end

   // Event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve)    stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_branch;
   logic [2:0]  ex_op;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int vectors = 0;
   int miscompares = 0;

   branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_op            (ex_op),
      .ex_a             (ex_a),
      .ex_b             (ex_b),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resolve(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
      ex_valid       = 1'b1;
      ex_branch      = 1'b1;
      ex_op          = op;
      ex_a           = a;
      ex_b           = b;
      ex_pc          = pc;
      ex_target      = tgt;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
   endtask

   task automatic idle();
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      if_pc = 32'h0;
      ex_valid = 1'b0; ex_branch = 1'b0; ex_op = 3'b000;
      ex_a = '0; ex_b = '0; ex_pc = '0; ex_target = '0;
      ex_pred_taken = 1'b0; ex_pred_target = '0;
      step();
      step();
      rst_n = 1'b1;

      // Reset state and empty-table lookup
      if_pc = 32'h100;
      #1;
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rst_pred_target", pred_target, 32'h104);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_redirect", redirect_pc, 32'h0);
      check("rst_branches", stat_branches, 32'd0);
      check("rst_mispredicts", stat_mispredicts, 32'd0);

      // BEQ taken at 0x100, predicted not-taken: allocate, flush to target
      resolve(3'b000, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 32'h104);
      step();
      idle();
      #1;
      check("beq_flush", {31'd0, flush}, 32'd1);
      check("beq_redirect", redirect_pc, 32'h200);
      check("beq_branches", stat_branches, 32'd1);
      check("beq_mispredicts", stat_mispredicts, 32'd1);
      check("beq_pred_taken", {31'd0, pred_taken}, 32'd1);
      check("beq_pred_target", pred_target, 32'h200);
      step();
      check("flush_one_cycle", {31'd0, flush}, 32'd0);
      check("redirect_hold", redirect_pc, 32'h200);

      // Non-branch in EX changes nothing
      ex_valid = 1'b1; ex_branch = 1'b0; ex_op = 3'b000; ex_a = 32'd1; ex_b = 32'd1;
      ex_pc = 32'h100; ex_target = 32'h999; ex_pred_taken = 1'b0;
      step();
      idle();
      #1;
      check("nonbr_flush", {31'd0, flush}, 32'd0);
      check("nonbr_branches", stat_branches, 32'd1);
      check("nonbr_pred_target", pred_target, 32'h200);

      // Not taken twice: counter 10 -> 01 -> 00
      resolve(3'b000, 32'd5, 32'd6, 32'h100, 32'h200, 1'b1, 32'h200);
      step();
      idle();
      #1;
      check("nt1_flush", {31'd0, flush}, 32'd1);
      check("nt1_redirect", redirect_pc, 32'h104);
      check("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("nt1_pred_target", pred_target, 32'h200);
      resolve(3'b000, 32'd5, 32'd6, 32'h100, 32'h200, 1'b0, 32'h200);
      step();
      idle();
      #1;
      check("nt2_flush", {31'd0, flush}, 32'd0);
      check("nt2_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("nt2_branches", stat_branches, 32'd3);
      check("nt2_mispredicts", stat_mispredicts, 32'd2);

      // Signed vs unsigned compare of 0xFFFFFFFF against 1
      if_pc = 32'h300;
      resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 1'b0, 32'h304);
      step();
      idle();
      #1;
      check("blt_flush", {31'd0, flush}, 32'd1);
      check("blt_redirect", redirect_pc, 32'h380);
      check("blt_pred_taken", {31'd0, pred_taken}, 32'd1);
      check("blt_pred_target", pred_target, 32'h380);
      resolve(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h380, 1'b1, 32'h380);
      step();
      idle();
      #1;
      check("bltu_flush", {31'd0, flush}, 32'd1);
      check("bltu_redirect", redirect_pc, 32'h304);
      check("bltu_pred_taken", {31'd0, pred_taken}, 32'd0);

      // Taken branch predicted taken to the wrong target still mispredicts
      resolve(3'b101, 32'd0, 32'd0, 32'h300, 32'h3C0, 1'b1, 32'h380);
      step();
      idle();
      #1;
      check("tgt_flush", {31'd0, flush}, 32'd1);
      check("tgt_redirect", redirect_pc, 32'h3C0);
      check("tgt_pred_target", pred_target, 32'h3C0);

      // Aliasing: 0x140 shares index 0 with 0x100 but differs in tag
      if_pc = 32'h140;
      #1;
      check("alias_miss_taken", {31'd0, pred_taken}, 32'd0);
      check("alias_miss_target", pred_target, 32'h144);
      resolve(3'b010, 32'd1, 32'd2, 32'h140, 32'h500, 1'b0, 32'h144);
      step();
      idle();
      #1;
      check("alias_alloc_taken", {31'd0, pred_taken}, 32'd1);
      check("alias_alloc_target", pred_target, 32'h500);
      if_pc = 32'h100;
      #1;
      check("alias_evict_taken", {31'd0, pred_taken}, 32'd0);
      check("alias_evict_target", pred_target, 32'h104);

      // Same-cycle lookup and update of one index sees old contents
      if_pc = 32'h140;
      resolve(3'b010, 32'd3, 32'd3, 32'h140, 32'h500, 1'b1, 32'h500);
      #1;
      check("nobypass_taken", {31'd0, pred_taken}, 32'd1);
      check("nobypass_target", pred_target, 32'h500);
      step();
      idle();
      #1;
      check("after_upd_taken", {31'd0, pred_taken}, 32'd0);

      // Reset wins over a simultaneous mispredict
      resolve(3'b000, 32'd7, 32'd7, 32'h180, 32'h600, 1'b0, 32'h184);
      rst_n = 1'b0;
      step();
      idle();
      rst_n = 1'b1;
      if_pc = 32'h180;
      #1;
      check("rstw_flush", {31'd0, flush}, 32'd0);
      check("rstw_redirect", redirect_pc, 32'h0);
      check("rstw_branches", stat_branches, 32'd0);
      check("rstw_mispredicts", stat_mispredicts, 32'd0);
      check("rstw_pred_taken", {31'd0, pred_taken}, 32'd0);
      check("rstw_pred_target", pred_target, 32'h184);
      if_pc = 32'h140;
      #1;
      check("rstw_empty_target", pred_target, 32'h144);
      if_pc = 32'h300;
      #1;
      check("rstw_empty_300", pred_target, 32'h304);

      // PC+4 wraps modulo 2^32
      if_pc = 32'hFFFF_FFFC;
      #1;
      check("pc_wrap", pred_target, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
